// File: rtl/trsq_pkg.sv
// Shared defaults and helpers for the TRSQ program-counter sequencer.
package trsq_pkg;

  localparam int PC_W_DEF        = 13;
  localparam int STACK_DEPTH_DEF = 4;
  localparam int IRQ_N_DEF       = 4;
  localparam int VEC_BASE_DEF    = 4;
  localparam int VEC_STRIDE_DEF  = 2;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index into n items, never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SP_W_DEF = sp_width(STACK_DEPTH_DEF);

  // Callers truncate to PC_W, which gives the required modulo wrap.
  function automatic logic [31:0] vec_addr(input int base, input int stride, input int id);
    return 32'(base + id * stride);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: push/pop take effect at the clock edge, top is combinational from registers.
// Push when full and pop when empty are ignored here; the caller flags them.
module ret_stack
  import trsq_pkg::*;
#(
  parameter  int W     = PC_W_DEF,
  parameter  int DEPTH = STACK_DEPTH_DEF,
  localparam int SP_W  = sp_width(DEPTH)
) (
  input  logic            clk_ip,
  input  logic            reset_ip,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    top,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = id_width(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));
  assign top    = mem[rd_idx];
  assign sp     = sp_q;

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk_ip) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: registered pc with call/return stack and prioritised vectored interrupts.
// Interrupt entry two cycles after the request edge; irq_take_op/irq_id_op are combinational from state only.
module pc_sequencer
  import trsq_pkg::*;
#(
  parameter  int PC_W        = PC_W_DEF,
  parameter  int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter  int IRQ_N       = IRQ_N_DEF,
  parameter  int VEC_BASE    = VEC_BASE_DEF,
  parameter  int VEC_STRIDE  = VEC_STRIDE_DEF,
  localparam int SP_W        = sp_width(STACK_DEPTH),
  localparam int ID_W        = id_width(IRQ_N)
) (
  input  logic             clk_ip,
  input  logic             reset_ip,
  input  logic             halt_ip,
  input  logic             jump_ip,
  input  logic             call_ip,
  input  logic             return_ip,
  input  logic             reti_ip,
  input  logic             skip_ip,
  input  logic [PC_W-1:0]  target_ip,
  input  logic [IRQ_N-1:0] irq_ip,
  input  logic             mask_wr_ip,
  input  logic [IRQ_N-1:0] mask_data_ip,
  output logic [PC_W-1:0]  pc_op,
  output logic             irq_take_op,
  output logic [ID_W-1:0]  irq_id_op,
  output logic             in_isr_op,
  output logic [IRQ_N-1:0] pend_op,
  output logic [SP_W-1:0]  sp_op,
  output logic             ovf_op,
  output logic             unf_op
);

  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic [IRQ_N-1:0] pend_q, pend_nxt, pend_clr;
  logic [IRQ_N-1:0] mask_q;
  logic [IRQ_N-1:0] irq_prev_q;
  logic             in_isr_q, in_isr_nxt;
  logic             ovf_q, ovf_nxt;
  logic             unf_q, unf_nxt;

  logic [IRQ_N-1:0] qual;
  logic             take;
  logic [ID_W-1:0]  take_id;

  logic             push_req, pop_req;
  logic [PC_W-1:0]  push_dat;
  logic [PC_W-1:0]  stk_top;
  logic             stk_full, stk_empty;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_vec;

  assign qual   = pend_q & mask_q;
  assign take   = (|qual) & ~in_isr_q;
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_vec = PC_W'(vec_addr(VEC_BASE, VEC_STRIDE, int'(take_id)));

  // Lowest qualifying channel wins; scanning downward lets the lowest overwrite.
  always_comb begin
    take_id = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (qual[i]) take_id = ID_W'(i);
    end
  end

  always_comb begin
    pc_nxt     = pc_inc;
    in_isr_nxt = in_isr_q;
    ovf_nxt    = ovf_q;
    unf_nxt    = unf_q;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    push_dat   = pc_inc;
    pend_clr   = '0;

    if (take) begin
      // A halted core resumes after the halt instruction on return.
      push_req           = 1'b1;
      push_dat           = halt_ip ? pc_inc : pc_q;
      pc_nxt             = pc_vec;
      in_isr_nxt         = 1'b1;
      pend_clr[take_id]  = 1'b1;
    end else if (halt_ip) begin
      pc_nxt = pc_q;
    end else if (jump_ip) begin
      pc_nxt = target_ip;
    end else if (call_ip) begin
      push_req = 1'b1;
      pc_nxt   = target_ip;
    end else if (return_ip || reti_ip) begin
      if (stk_empty) begin
        unf_nxt = 1'b1;
      end else begin
        pop_req = 1'b1;
        pc_nxt  = stk_top;
      end
      if (reti_ip) in_isr_nxt = 1'b0;
    end else if (skip_ip) begin
      pc_nxt = pc_q + PC_W'(2);
    end

    if (push_req && stk_full) ovf_nxt = 1'b1;

    // A fresh edge on the channel being taken keeps it pending.
    pend_nxt = (pend_q & ~pend_clr) | (irq_ip & ~irq_prev_q);
  end

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      pc_q       <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      in_isr_q   <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pc_q       <= pc_nxt;
      pend_q     <= pend_nxt;
      irq_prev_q <= irq_ip;
      in_isr_q   <= in_isr_nxt;
      ovf_q      <= ovf_nxt;
      unf_q      <= unf_nxt;
      if (mask_wr_ip) mask_q <= mask_data_ip;
    end
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_ip   (clk_ip),
    .reset_ip (reset_ip),
    .push     (push_req),
    .pop      (pop_req),
    .din      (push_dat),
    .top      (stk_top),
    .sp       (sp_op),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  assign pc_op       = pc_q;
  assign irq_take_op = take;
  assign irq_id_op   = take ? take_id : '0;
  assign in_isr_op   = in_isr_q;
  assign pend_op     = pend_q;
  assign ovf_op      = ovf_q;
  assign unf_op      = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded random and directed bench for pc_sequencer at default parameters.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_HALT = 6'b000001;
  localparam logic [5:0] S_JUMP = 6'b000010;
  localparam logic [5:0] S_CALL = 6'b000100;
  localparam logic [5:0] S_RET  = 6'b001000;
  localparam logic [5:0] S_RETI = 6'b010000;
  localparam logic [5:0] S_SKIP = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 0, jump = 0, call = 0, ret = 0, reti = 0, skip = 0;
  logic [12:0] target = '0;
  logic [3:0]  irq = '0;
  logic        mask_wr = 0;
  logic [3:0]  mask_data = '0;
  logic [12:0] pc;
  logic        irq_take;
  logic [1:0]  irq_id;
  logic        in_isr;
  logic [3:0]  pend;
  logic [2:0]  sp;
  logic        ovf, unf;

  pc_sequencer dut (
    .clk_ip(clk), .reset_ip(reset),
    .halt_ip(halt), .jump_ip(jump), .call_ip(call), .return_ip(ret),
    .reti_ip(reti), .skip_ip(skip), .target_ip(target), .irq_ip(irq),
    .mask_wr_ip(mask_wr), .mask_data_ip(mask_data),
    .pc_op(pc), .irq_take_op(irq_take), .irq_id_op(irq_id), .in_isr_op(in_isr),
    .pend_op(pend), .sp_op(sp), .ovf_op(ovf), .unf_op(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc; int sp; int pend; int isr; int ovf; int unf; int take; int id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int       m_pc;
  int       m_stk[$];
  bit [3:0] m_pend, m_mask, m_prev;
  bit       m_isr, m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pick();
    int id = -1;
    if (!m_isr)
      for (int i = 3; i >= 0; i--)
        if (m_pend[i] && m_mask[i]) id = i;
    return id;
  endfunction

  function automatic void m_push(input int v);
    if (m_stk.size() == 4) m_ovf = 1;
    else m_stk.push_back(v % 8192);
  endfunction

  function automatic void m_reset();
    m_pc = 0; m_stk.delete(); m_pend = 0; m_mask = 0; m_prev = 0;
    m_isr = 0; m_ovf = 0; m_unf = 0;
  endfunction

  // Drive one cycle at a negedge, advance the model, queue the expectation, return at the next negedge.
  task automatic cyc(input logic [5:0] st, input logic [12:0] tgt, input logic [3:0] irqv,
                     input logic mwr, input logic [3:0] mdat);
    int       t;
    bit [3:0] clr;
    exp_t     e;
    {skip, reti, ret, call, jump, halt} = st;
    target = tgt; irq = irqv; mask_wr = mwr; mask_data = mdat;

    t = pick();
    clr = 0;
    if (t >= 0) begin
      m_push(st[0] ? m_pc + 1 : m_pc);
      m_pc = (4 + 2 * t) % 8192;
      m_isr = 1;
      clr[t] = 1;
    end else if (st[0]) begin
      m_pc = m_pc;
    end else if (st[1]) begin
      m_pc = tgt;
    end else if (st[2]) begin
      m_push(m_pc + 1);
      m_pc = tgt;
    end else if (st[3] || st[4]) begin
      if (m_stk.size() == 0) begin
        m_unf = 1;
        m_pc = (m_pc + 1) % 8192;
      end else begin
        m_pc = m_stk.pop_back();
      end
      if (st[4]) m_isr = 0;
    end else if (st[5]) begin
      m_pc = (m_pc + 2) % 8192;
    end else begin
      m_pc = (m_pc + 1) % 8192;
    end
    m_pend = (m_pend & ~clr) | (irqv & ~m_prev);
    m_prev = irqv;
    if (mwr) m_mask = mdat;

    e.pc = m_pc; e.sp = m_stk.size(); e.pend = m_pend; e.isr = m_isr;
    e.ovf = m_ovf; e.unf = m_unf;
    t = pick();
    e.take = (t >= 0); e.id = (t >= 0) ? t : 0;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(S_IDLE, '0, irq, 1'b0, '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_take"}, irq_take, 0);
    chk({tag, "_id"}, irq_id, 0);
    chk({tag, "_isr"}, in_isr, 0);
    chk({tag, "_pend"}, pend, 0);
    chk({tag, "_sp"}, sp, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_unf"}, unf, 0);
  endtask

  // Called at a negedge with the queue drained; reset lands mid-cycle.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    {skip, reti, ret, call, jump, halt} = S_IDLE;
    irq = '0; mask_wr = 0;
    #1;
    chk_reset_outputs("async_rst");
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every registered update is compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("sp", sp, e.sp);
        chk("pend", pend, e.pend);
        chk("in_isr", in_isr, e.isr);
        chk("ovf", ovf, e.ovf);
        chk("unf", unf, e.unf);
        chk("irq_take", irq_take, e.take);
        chk("irq_id", irq_id, e.id);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  st;
    logic [3:0]  irqv;
    logic [12:0] tgt;
    int          r;

    m_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Sequential fetch and wrap at the top of the address space.
    idle(3);
    cyc(S_JUMP, 13'h1FFD, '0, 0, '0);
    idle(3);
    cyc(S_JUMP, 13'h1FFF, '0, 0, '0);
    cyc(S_SKIP, '0, '0, 0, '0);

    // Single call/return, then overflow and underflow.
    cyc(S_JUMP, 13'h010, '0, 0, '0);
    cyc(S_CALL, 13'h100, '0, 0, '0);
    cyc(S_RET, '0, '0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(S_CALL, 13'(13'h200 + 13'(i * 16)), '0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(S_RET, '0, '0, 0, '0);

    // Two simultaneous masked edges: lowest enabled channel first, the other after reti.
    cyc(S_JUMP, 13'h01F, '0, 1, 4'b1010);
    cyc(S_IDLE, '0, 4'b1010, 0, '0);
    cyc(S_IDLE, '0, 4'b1010, 0, '0);
    cyc(S_RETI, '0, 4'b1010, 0, '0);
    cyc(S_IDLE, '0, 4'b0000, 0, '0);
    cyc(S_RETI, '0, 4'b0000, 0, '0);

    // Halted core wakes when the mask enables a latched request.
    cyc(S_JUMP, 13'h030, '0, 1, 4'b0000);
    cyc(S_HALT, '0, 4'b0001, 0, '0);
    cyc(S_HALT, '0, 4'b0001, 0, '0);
    cyc(S_HALT, '0, 4'b0001, 1, 4'b0001);
    cyc(S_HALT, '0, 4'b0001, 0, '0);
    cyc(S_HALT, '0, 4'b0001, 0, '0);
    cyc(S_RETI, '0, 4'b0001, 0, '0);
    idle(1);

    // Async reset inside an ISR with two stacked return addresses.
    cyc(S_CALL, 13'h300, 4'b0000, 0, '0);
    cyc(S_IDLE, '0, 4'b0001, 0, '0);
    cyc(S_IDLE, '0, 4'b0001, 0, '0);
    mid_reset();
    idle(3);

    // Random traffic with periodic asynchronous resets.
    irqv = '0;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if      (r < 6)  st = S_HALT;
      else if (r < 14) st = S_JUMP;
      else if (r < 24) st = S_CALL;
      else if (r < 34) st = S_RET;
      else if (r < 42) st = S_RETI;
      else if (r < 50) st = S_SKIP;
      else             st = S_IDLE;
      tgt = ($urandom_range(0, 3) == 0) ? 13'(13'h1FFC + 13'($urandom_range(0, 3)))
                                        : 13'($urandom);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) irqv[b] = ~irqv[b];
      cyc(st, tgt, irqv, ($urandom_range(0, 19) == 0), 4'($urandom));
      if (k % 500 == 499) begin
        mid_reset();
        irqv = '0;
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
